// File: rtl/cla_pkg.sv
// ----------------------------------------------------------------------------
// cla_pkg
// Shared constants and types for the pipelined lookahead-borrow subtractor.
//   CLA_WIDTH : default operand/result width (even, >= 4)
//   CLA_NIB   : default lookahead group width (must divide CLA_WIDTH/2)
//   s1_rec_t  : payload held between stage 1 and stage 2
// The stage-1 record is sized from CLA_WIDTH, so a different datapath width
// is built by changing the constants here (the top's WIDTH tracks them).
// ----------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_WIDTH = 8;
  localparam int CLA_NIB   = 4;
  localparam int CLA_HALF  = CLA_WIDTH / 2;

  // Low-half result plus everything stage 2 needs to finish the high half.
  typedef struct packed {
    logic [CLA_HALF-1:0] lo_d;    // low-half difference
    logic                borrow;  // borrow out of the low half
    logic [CLA_HALF-1:0] a_hi;    // high half of the minuend
    logic [CLA_HALF-1:0] b_hi;    // high half of the subtrahend
  } s1_rec_t;

endpackage

// File: rtl/cla_nibble_sub.sv
// ----------------------------------------------------------------------------
// cla_nibble_sub
// Combinational NIB-bit subtractor with lookahead borrow.
//   a, b   : minuend / subtrahend group bits
//   bin    : borrow into the group
//   d      : a - b - bin over the group
//   bout   : borrow out of the group
//   grp_g  : group generate  (group borrows out regardless of bin)
//   grp_p  : group propagate (group passes bin straight through)
// Bit terms: generate = ~a & b, propagate = ~(a ^ b).
// ----------------------------------------------------------------------------
module cla_nibble_sub #(
  parameter int NIB = 4
) (
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           bin,
  output logic [NIB-1:0] d,
  output logic           bout,
  output logic           grp_g,
  output logic           grp_p
);

  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB:0]   br;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Group G/P kept in its own block that never reads bin, so the group
  // terms stay independent of the incoming borrow when groups are chained.
  always_comb begin
    grp_g = g[NIB-1];
    grp_p = p[NIB-1];
    for (int j = NIB - 2; j >= 0; j--) begin
      grp_g = grp_g | (grp_p & g[j]);
      grp_p = grp_p & p[j];
    end
  end

  // Every internal borrow is expanded as a flat sum of products from the
  // bit G/P terms and bin, rather than rippling through the previous bit.
  always_comb begin : b_borrow
    logic gg;
    logic pp;
    br[0] = bin;
    for (int i = 0; i < NIB; i++) begin
      gg = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gg = gg | (pp & g[j]);
        pp = pp & p[j];
      end
      br[i+1] = gg | (pp & bin);
    end
  end

  assign d    = a ^ b ^ br[NIB-1:0];
  assign bout = br[NIB];

endmodule

// File: rtl/cla_sub_pipe.sv
// ----------------------------------------------------------------------------
// cla_sub_pipe
// Two-stage pipelined subtractor d = a - b - bin (mod 2^WIDTH) with
// valid/ready handshakes on both sides.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, bin)
//   out_valid / out_ready: result handshake (d, bout, ovf)
//   bout                 : 1 iff unsigned a < b + bin
//   ovf                  : two's-complement overflow of the subtraction
// Stage 1 resolves the low half; stage 2 resolves the high half using the
// registered low-half borrow. Each half is split into NIB-bit lookahead groups.
// ----------------------------------------------------------------------------
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int NIB   = CLA_NIB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;
  localparam int NGRP = HALF / NIB;

  // ---------------- handshake / stage control ----------------
  logic    s1_valid;
  logic    s2_valid;
  s1_rec_t s1_q;
  logic    s2_free;   // stage 2 can take a new entry this cycle
  logic    s1_move;   // stage 1 hands its entry to stage 2
  logic    in_xfer;

  assign s2_free   = ~s2_valid | out_ready;
  assign s1_move   = s1_valid & s2_free;
  assign in_ready  = ~rst & (~s1_valid | s2_free);
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = s2_valid;

  // ---------------- stage 1: low half ----------------
  logic [HALF-1:0] lo_d;
  logic [NGRP-1:0] lo_g, lo_p, lo_bout, lo_cin;
  logic            lo_borrow;

  // Group-level lookahead: each group's borrow-in comes from the lower
  // groups' G/P, so the groups do not wait on each other's internal chains.
  always_comb begin : b_lo_chain
    logic c;
    c = bin;
    for (int k = 0; k < NGRP; k++) begin
      lo_cin[k] = c;
      c         = lo_g[k] | (lo_p[k] & c);
    end
    lo_borrow = c;
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_lo
    cla_nibble_sub #(.NIB(NIB)) u_nib (
      .a     (a[k*NIB +: NIB]),
      .b     (b[k*NIB +: NIB]),
      .bin   (lo_cin[k]),
      .d     (lo_d[k*NIB +: NIB]),
      .bout  (lo_bout[k]),
      .grp_g (lo_g[k]),
      .grp_p (lo_p[k])
    );
  end

  // ---------------- stage 2: high half ----------------
  logic [HALF-1:0] hi_d;
  logic [NGRP-1:0] hi_g, hi_p, hi_bout, hi_cin;
  logic            hi_borrow;
  logic            ovf_n;

  always_comb begin : b_hi_chain
    logic c;
    c = s1_q.borrow;
    for (int k = 0; k < NGRP; k++) begin
      hi_cin[k] = c;
      c         = hi_g[k] | (hi_p[k] & c);
    end
    hi_borrow = c;
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_hi
    cla_nibble_sub #(.NIB(NIB)) u_nib (
      .a     (s1_q.a_hi[k*NIB +: NIB]),
      .b     (s1_q.b_hi[k*NIB +: NIB]),
      .bin   (hi_cin[k]),
      .d     (hi_d[k*NIB +: NIB]),
      .bout  (hi_bout[k]),
      .grp_g (hi_g[k]),
      .grp_p (hi_p[k])
    );
  end

  // The per-group bout equals the chained G/P result above; chaining on G/P
  // keeps the group borrows parallel, so the nibble bouts are left unread.
  logic unused_bout;
  assign unused_bout = ^{lo_bout, hi_bout};

  // Operands of differing sign overflow when the result's sign leaves a's.
  assign ovf_n = (s1_q.a_hi[HALF-1] != s1_q.b_hi[HALF-1]) &
                 (hi_d[HALF-1] != s1_q.a_hi[HALF-1]);

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      d        <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_free)  s2_valid <= s1_valid;
      // Outputs only change when a new entry lands, so a stalled result holds.
      if (s1_move) begin
        d    <= {hi_d, s1_q.lo_d};
        bout <= hi_borrow;
        ovf  <= ovf_n;
      end
    end
  end

  // NOTE: the stage-1 payload has no reset; it is only read while s1_valid
  // is set, and the valid bit is what reset clears.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_q.lo_d   <= lo_d;
      s1_q.borrow <= lo_borrow;
      s1_q.a_hi   <= a[WIDTH-1:HALF];
      s1_q.b_hi   <= b[WIDTH-1:HALF];
    end
  end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// ----------------------------------------------------------------------------
// tb_cla_sub_pipe
// Self-checking bench for cla_sub_pipe (WIDTH=8, NIB=4). Expected results are
// pushed to a scoreboard queue when an operand is accepted and popped when a
// result is taken. Inputs change on the falling edge; outputs are sampled 1
// time unit later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_cla_sub_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  cla_sub_pipe #(.WIDTH(W), .NIB(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  int   stall_lo = -1;
  int   stall_hi = -1;
  bit   rand_ready = 1'b0;
  bit   holding    = 1'b0;
  bit   saw_block  = 1'b0;
  res_t held;
  logic took;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, overflow from the signed range.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int   diff;
    int   sx;
    int   sy;
    int   sr;
    res_t r;
    diff   = int'(x) - int'(y) - int'(bi);
    r.d    = diff[W-1:0];
    r.bout = (diff < 0);
    sx     = $signed(x);
    sy     = $signed(y);
    sr     = sx - sy - int'(bi);
    r.ovf  = (sr < -(2 ** (W - 1))) || (sr > (2 ** (W - 1)) - 1);
    return r;
  endfunction

  // One clock cycle: drive, sample/score, advance to the next falling edge.
  task automatic tick(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic bi, input res_t exp, output logic acc);
    in_valid  = iv;
    a         = av;
    b         = bv;
    bin       = bi;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : !(cyc >= stall_lo && cyc <= stall_hi);
    #1;
    if (holding) chk("hold_stable", {out_valid, d, bout, ovf}, {1'b1, held});
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'd0);
      else                chk("result", {d, bout, ovf}, sb.pop_front());
    end
    if (iv && !in_ready) saw_block = 1'b1;
    acc = iv && in_ready;
    if (acc) sb.push_back(exp);
    holding = out_valid && !out_ready;
    held    = {d, bout, ovf};
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                      input res_t exp);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) tick(1'b1, av, bv, bi, exp, acc);
    if (!acc) chk("send_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic sendm(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    send(av, bv, bi, model(av, bv, bi));
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) tick(1'b0, '0, '0, 1'b0, '0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) idle(1);
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int c0;
    int n0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;

    // ---- reset state ----
    @(negedge clk);
    chk("rst_outputs", {out_valid, d, bout, ovf}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

    // ---- latency: 0x5A - 0x13 ----
    tick(1'b1, 8'h5A, 8'h13, 1'b0, {8'h47, 1'b0, 1'b0}, took);
    chk("lat_accept", {31'b0, took}, 32'd1);
    chk("lat_cycle1", {31'b0, out_valid}, 32'd0);
    idle(1);
    chk("lat_cycle2", {31'b0, out_valid}, 32'd1);
    chk("lat_value", {d, bout, ovf}, {8'h47, 1'b0, 1'b0});
    drain();

    // ---- wrap-around and overflow corners ----
    send(8'h00, 8'h00, 1'b1, {8'hFF, 1'b1, 1'b0});
    send(8'h10, 8'h20, 1'b0, {8'hF0, 1'b1, 1'b0});
    send(8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b1});
    send(8'h7F, 8'hFF, 1'b0, {8'h80, 1'b1, 1'b1});
    send(8'hFF, 8'hFF, 1'b1, {8'hFF, 1'b1, 1'b0});
    send(8'h80, 8'h00, 1'b1, {8'h7F, 1'b0, 1'b1});
    drain();

    // ---- full throughput, one transfer per cycle ----
    c0 = cyc;
    for (int i = 0; i < 8; i++) sendm(W'($urandom), W'($urandom), 1'($urandom));
    chk("throughput_cycles", cyc - c0, 32'd8);
    drain();

    // ---- 10-operand stream with out_ready low for cycles 3..6 ----
    stall_lo  = cyc + 3;
    stall_hi  = cyc + 6;
    saw_block = 1'b0;
    n0        = n_out;
    for (int i = 0; i < 10; i++) sendm(W'(8'h11 * i + 3), W'(8'h27 * i), 1'(i));
    drain();
    chk("stream_backpressure", {31'b0, saw_block}, 32'd1);
    chk("stream_count", n_out - n0, 32'd10);
    stall_lo = -1;
    stall_hi = -1;

    // ---- reset with both stages full ----
    stall_lo = cyc;
    stall_hi = cyc + 1000;
    sendm(8'h33, 8'h11, 1'b0);
    sendm(8'h44, 8'h22, 1'b1);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_outputs", {out_valid, d, bout, ovf}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    rst      = 1'b0;
    sb.delete();
    holding  = 1'b0;
    stall_lo = -1;
    stall_hi = -1;
    n0       = n_out;
    idle(6);
    chk("no_stale_after_rst", n_out - n0, 32'd0);

    // ---- random operands with random out_ready ----
    rand_ready = 1'b1;
    n0         = n_out;
    for (int i = 0; i < 10000; i++) sendm(W'($urandom), W'($urandom), 1'($urandom));
    drain();
    chk("random_count", n_out - n0, 32'd10000);
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
